// File: rtl/memory_bus_arbiter.sv
// ============================================================================
// Module   : memory_bus_arbiter
// Brief    : Sequenced grant FSM sharing one single-port Memory between the
//            interpreter (port 0), core instruction fetch (port 1) and core
//            data (port 2). One request is latched, run on the memory side,
//            and answered with a one-cycle response pulse to its owner.
//            Optional macro MEMORY_BUS_ARBITER_TIMEOUT_EN adds a memory
//            response watchdog and the sticky o_timeout_error output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_BITS   = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_priority_mode,
  input  logic                  i_core_enable,
  input  logic                  i_m0_read,
  input  logic                  i_m0_write,
  input  logic [ADDR_WIDTH-1:0] i_m0_address,
  input  logic [DATA_WIDTH-1:0] i_m0_write_data,
  output logic [DATA_WIDTH-1:0] o_m0_read_data,
  output logic                  o_m0_response,
  input  logic                  i_m1_read,
  input  logic                  i_m1_write,
  input  logic [ADDR_WIDTH-1:0] i_m1_address,
  input  logic [DATA_WIDTH-1:0] i_m1_write_data,
  output logic [DATA_WIDTH-1:0] o_m1_read_data,
  output logic                  o_m1_response,
  input  logic                  i_m2_read,
  input  logic                  i_m2_write,
  input  logic [ADDR_WIDTH-1:0] i_m2_address,
  input  logic [DATA_WIDTH-1:0] i_m2_write_data,
  output logic [DATA_WIDTH-1:0] o_m2_read_data,
  output logic                  o_m2_response,
  output logic                  o_memory_read,
  output logic                  o_memory_write,
  output logic [ADDR_WIDTH-1:0] o_memory_address,
  output logic [DATA_WIDTH-1:0] o_memory_write_data,
  input  logic [DATA_WIDTH-1:0] i_memory_read_data,
  input  logic                  i_memory_response,
  output logic [2:0]            o_grant,
  output logic                  o_busy
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
  ,
  output logic                  o_timeout_error
`endif
);

  // The watchdog counter must be able to reach TIMEOUT_CYCLES-1.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > (1 << TIMEOUT_BITS))) begin : g_bad_timeout_cfg
    $error("memory_bus_arbiter: TIMEOUT_BITS too small for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_last;       // index of the port served most recently
  logic [1:0]            r_idx;        // index of the port owning the transaction
  logic [2:0]            r_grant;
  logic [2:0]            r_resp;
  logic                  r_busy;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rdata [3];

`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] r_timer;
  logic                    r_timeout_error;
`endif

  // Per-port request views so the winner can be picked by index.
  logic [2:0]            w_req_rd;
  logic [2:0]            w_req_wr;
  logic [2:0]            w_elig;
  logic [ADDR_WIDTH-1:0] w_addr  [3];
  logic [DATA_WIDTH-1:0] w_wdata [3];
  logic                  w_found;
  logic [1:0]            w_win;
  logic [1:0]            w_cand;

  assign w_req_rd   = {i_m2_read,  i_m1_read,  i_m0_read};
  assign w_req_wr   = {i_m2_write, i_m1_write, i_m0_write};
  assign w_addr[0]  = i_m0_address;
  assign w_addr[1]  = i_m1_address;
  assign w_addr[2]  = i_m2_address;
  assign w_wdata[0] = i_m0_write_data;
  assign w_wdata[1] = i_m1_write_data;
  assign w_wdata[2] = i_m2_write_data;

  // Core ports only compete while the core is enabled.
  assign w_elig = (w_req_rd | w_req_wr) & {i_core_enable, i_core_enable, 1'b1};

  // Winner selection: fixed order 0,2,1 or round-robin after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_cand  = r_last;
    if (i_priority_mode) begin
      if (w_elig[0]) begin
        w_found = 1'b1;
        w_win   = 2'd0;
      end else if (w_elig[2]) begin
        w_found = 1'b1;
        w_win   = 2'd2;
      end else if (w_elig[1]) begin
        w_found = 1'b1;
        w_win   = 2'd1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        w_cand = (w_cand == 2'd2) ? 2'd0 : (w_cand + 2'd1);
        if (!w_found && w_elig[w_cand]) begin
          w_found = 1'b1;
          w_win   = w_cand;
        end
      end
    end
  end

  // Grant FSM with all outputs registered; reset abandons any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd2;
      r_idx       <= 2'd0;
      r_grant     <= 3'b000;
      r_resp      <= 3'b000;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int n = 0; n < 3; n++) r_rdata[n] <= '0;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
      r_timer         <= '0;
      r_timeout_error <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx       <= w_win;
            r_grant     <= 3'b001 << w_win;
            r_busy      <= 1'b1;
            // A write wins when both read and write are raised.
            r_mem_write <= w_req_wr[w_win];
            r_mem_read  <= ~w_req_wr[w_win];
            r_mem_addr  <= w_addr[w_win];
            r_mem_wdata <= w_wdata[w_win];
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (i_memory_response) begin
            r_rdata[r_idx] <= r_mem_write ? '0 : i_memory_read_data;
            r_resp         <= r_grant;
            r_last         <= r_idx;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_state        <= S_RESPOND;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
          end else if (r_timer == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1)) begin
            r_rdata[r_idx]  <= DATA_WIDTH'(32'hDEADBEEF);
            r_resp          <= r_grant;
            r_last          <= r_idx;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_timeout_error <= 1'b1;
            r_state         <= S_RESPOND;
          end else begin
            r_timer <= r_timer + 1'b1;
`endif
          end
        end
        S_RESPOND: begin
          r_resp      <= 3'b000;
          r_grant     <= 3'b000;
          r_busy      <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          for (int n = 0; n < 3; n++) r_rdata[n] <= '0;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
          r_timer <= '0;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_m0_read_data      = r_rdata[0];
  assign o_m1_read_data      = r_rdata[1];
  assign o_m2_read_data      = r_rdata[2];
  assign o_m0_response       = r_resp[0];
  assign o_m1_response       = r_resp[1];
  assign o_m2_response       = r_resp[2];
  assign o_memory_read       = r_mem_read;
  assign o_memory_write      = r_mem_write;
  assign o_memory_address    = r_mem_addr;
  assign o_memory_write_data = r_mem_wdata;
  assign o_grant             = r_grant;
  assign o_busy              = r_busy;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
  assign o_timeout_error     = r_timeout_error;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
// ============================================================================
// Module   : tb_memory_bus_arbiter
// Brief    : Directed self-checking bench for memory_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        priority_mode, core_enable;
  logic        m0_read, m0_write, m1_read, m1_write, m2_read, m2_write;
  logic [31:0] m0_address, m1_address, m2_address;
  logic [31:0] m0_write_data, m1_write_data, m2_write_data;
  logic [31:0] m0_read_data, m1_read_data, m2_read_data;
  logic        m0_response, m1_response, m2_response;
  logic        memory_read, memory_write, memory_response;
  logic [31:0] memory_address, memory_write_data, memory_read_data;
  logic [2:0]  grant;
  logic        busy;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
  logic        timeout_error;
`endif

  int          total = 0;
  int          bad   = 0;
  logic        mem_auto;
  logic        mem_prev;
  logic [31:0] mem_data;
  logic [2:0]  v;

  always #5 clk = ~clk;

  memory_bus_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .i_priority_mode     (priority_mode),
    .i_core_enable       (core_enable),
    .i_m0_read           (m0_read),
    .i_m0_write          (m0_write),
    .i_m0_address        (m0_address),
    .i_m0_write_data     (m0_write_data),
    .o_m0_read_data      (m0_read_data),
    .o_m0_response       (m0_response),
    .i_m1_read           (m1_read),
    .i_m1_write          (m1_write),
    .i_m1_address        (m1_address),
    .i_m1_write_data     (m1_write_data),
    .o_m1_read_data      (m1_read_data),
    .o_m1_response       (m1_response),
    .i_m2_read           (m2_read),
    .i_m2_write          (m2_write),
    .i_m2_address        (m2_address),
    .i_m2_write_data     (m2_write_data),
    .o_m2_read_data      (m2_read_data),
    .o_m2_response       (m2_response),
    .o_memory_read       (memory_read),
    .o_memory_write      (memory_write),
    .o_memory_address    (memory_address),
    .o_memory_write_data (memory_write_data),
    .i_memory_read_data  (memory_read_data),
    .i_memory_response   (memory_response),
    .o_grant             (grant),
    .o_busy              (busy)
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
    ,
    .o_timeout_error     (timeout_error)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rv();
    return {m2_response, m1_response, m0_response};
  endfunction

  // One clock; the Memory model answers one cycle after it sees a request.
  task automatic tick();
    @(posedge clk);
    #1;
    memory_read_data = mem_data;
    if (mem_auto) begin
      memory_response = (memory_read | memory_write) & mem_prev & ~memory_response;
      mem_prev        = memory_read | memory_write;
    end
  endtask

  task automatic wait_resp(output logic [2:0] r, input int budget);
    int n = 0;
    r = rv();
    while (r == 3'b000 && n < budget) begin
      tick();
      n++;
      r = rv();
    end
    if (r == 3'b000) chk("resp_wait_expired", 32'(r), 32'd1);
  endtask

  task automatic clear_reqs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; m2_read = 0; m2_write = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_reqs();
    memory_response = 0;
    mem_prev        = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  initial begin
    reset = 0; priority_mode = 0; core_enable = 1;
    clear_reqs();
    m0_address = 0; m1_address = 0; m2_address = 0;
    m0_write_data = 0; m1_write_data = 0; m2_write_data = 0;
    memory_response = 0; memory_read_data = 0;
    mem_auto = 1; mem_prev = 0; mem_data = 0;

    // Reset state
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rw", 32'({memory_read, memory_write}), 32'd0);
    chk("rst_resp", 32'(rv()), 32'd0);
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeout_error), 32'd0);
`endif
    do_reset();

    // Port 0 read, Memory answers after one cycle
    mem_data = 32'hCAFEBABE;
    m0_read = 1; m0_address = 32'h10;                 // cycle 0
    tick();                                            // cycle 1
    chk("t1_mem_read", 32'(memory_read), 32'd1);
    chk("t1_mem_addr", memory_address, 32'h10);
    chk("t1_grant", 32'(grant), 32'b001);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();                                            // cycle 2
    chk("t1_no_early_resp", 32'(rv()), 32'd0);
    tick();                                            // cycle 3
    chk("t1_resp", 32'(rv()), 32'b001);
    chk("t1_rdata", m0_read_data, 32'hCAFEBABE);
    chk("t1_grant_resp", 32'(grant), 32'b001);
    chk("t1_mem_read_drop", 32'(memory_read), 32'd0);
    m0_read = 0;
    tick();                                            // cycle 4
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_rdata", m0_read_data, 32'd0);

    // Round-robin rotation with all ports reading continuously
    do_reset();
    mem_data = 32'h0BADF00D;
    m0_read = 1; m1_read = 1; m2_read = 1;
    m0_address = 32'h100; m1_address = 32'h104; m2_address = 32'h108;
    for (int t = 0; t < 6; t++) begin
      wait_resp(v, 20);
      chk("rr_order", 32'(v), 32'(3'b001 << (t % 3)));
      chk("rr_grant", 32'(grant), 32'(3'b001 << (t % 3)));
      tick();
    end
    chk("rr_data_p2", m2_read_data, 32'd0);
    clear_reqs();
    tick(); tick(); tick(); tick();

    // Fixed priority 0 > 2 > 1
    do_reset();
    priority_mode = 1;
    m1_read = 1; m1_address = 32'h200;
    m2_read = 1; m2_address = 32'h300;
    wait_resp(v, 20);
    chk("fp_first", 32'(v), 32'b100);
    m2_read = 0; m0_read = 1; m0_address = 32'h10;    // port 0 arrives in RESPOND
    tick();
    wait_resp(v, 20);
    chk("fp_second", 32'(v), 32'b001);
    m0_read = 0;
    tick();
    wait_resp(v, 20);
    chk("fp_third", 32'(v), 32'b010);
    m1_read = 0; priority_mode = 0;
    tick();

    // core_enable gating, then port 1 wins after last_grant=2
    do_reset();
    core_enable = 0;
    m1_write = 1; m1_address = 32'h400; m1_write_data = 32'h12345678;
    m2_write = 1; m2_address = 32'h500; m2_write_data = 32'h12345678;
    tick(); tick(); tick();
    chk("ce_no_write", 32'(memory_write), 32'd0);
    chk("ce_not_busy", 32'(busy), 32'd0);
    core_enable = 1;
    tick();
    chk("ce_grant", 32'(grant), 32'b010);
    chk("ce_mem_write", 32'({memory_read, memory_write}), 32'b01);
    chk("ce_wdata", memory_write_data, 32'h12345678);
    chk("ce_addr", memory_address, 32'h400);
    wait_resp(v, 20);
    chk("ce_resp1", 32'(v), 32'b010);
    m1_write = 0;
    tick();
    wait_resp(v, 20);
    chk("ce_resp2", 32'(v), 32'b100);
    m2_write = 0;
    tick();

    // Read and write both high: write wins, response data zero
    do_reset();
    mem_data = 32'h55AA55AA;
    m2_read = 1; m2_write = 1; m2_address = 32'h20; m2_write_data = 32'hFF;
    tick();
    chk("rw_ops", 32'({memory_read, memory_write}), 32'b01);
    chk("rw_addr", memory_address, 32'h20);
    chk("rw_wdata", memory_write_data, 32'hFF);
    wait_resp(v, 20);
    chk("rw_resp", 32'(v), 32'b100);
    chk("rw_rdata_zero", m2_read_data, 32'd0);
    clear_reqs();
    tick();

    // Stray memory_response while idle is ignored
    mem_auto = 0;
    memory_response = 1;
    tick(); tick();
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_resp", 32'(rv()), 32'd0);
    memory_response = 0;

    // Reset asserted during ACCESS
    do_reset();
    m1_read = 1; m1_address = 32'h600;
    tick();
    chk("ra_grant", 32'(grant), 32'b010);
    chk("ra_mem_read", 32'(memory_read), 32'd1);
    tick();
    reset = 0;
    #1;
    chk("ra_grant_clr", 32'(grant), 32'd0);
    chk("ra_outs_clr", 32'({busy, memory_read, memory_write}), 32'd0);
    chk("ra_addr_clr", memory_address, 32'd0);
    tick();
    chk("ra_no_pulse", 32'(rv()), 32'd0);
    reset = 1;
    mem_auto = 1; mem_prev = 0; mem_data = 32'h600DD00D;
    tick();
    wait_resp(v, 20);
    chk("ra_after_resp", 32'(v), 32'b010);
    chk("ra_after_data", m1_read_data, 32'h600DD00D);
    m1_read = 0;
    tick();

`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
    // Memory never answers: watchdog fires
    do_reset();
    mem_auto = 0;
    memory_response = 0;
    m0_read = 1; m0_address = 32'h700;
    wait_resp(v, 1100);
    chk("to_resp", 32'(v), 32'b001);
    chk("to_data", m0_read_data, 32'hDEADBEEF);
    chk("to_flag", 32'(timeout_error), 32'd1);
    m0_read = 0;
    tick();
    chk("to_mem_drop", 32'(memory_read), 32'd0);
    chk("to_sticky", 32'(timeout_error), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares one single-port Memory between three requesters: interpreter (port 0), core instruction fetch (port 1) and core data (port 2).
- Sits between the interpreter/core buses and a Memory instance. Replaces static mux-selector steering with a sequenced grant FSM.
- Each requester uses the codebase read/write/response handshake. The arbiter latches one request, runs it on the memory side and returns a one-cycle response to the winner.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- TIMEOUT_CYCLES, 1024, memory-response wait limit (used only with the optional feature).
- TIMEOUT_BITS, 11, counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- priority_mode  in  1  0 = round-robin, 1 = fixed priority 0>2>1.
- core_enable  in  1  0 = only port 0 eligible for grant.
- mN_read  in  1  read request, level, N=0..2.
- mN_write  in  1  write request, level, N=0..2.
- mN_address  in  ADDR_WIDTH  request address.
- mN_write_data  in  DATA_WIDTH  write data.
- mN_read_data  out  DATA_WIDTH  read data, valid with mN_response.
- mN_response  out  1  one-cycle completion pulse.
- memory_read  out  1  to Memory.
- memory_write  out  1  to Memory.
- memory_address  out  ADDR_WIDTH  to Memory.
- memory_write_data  out  DATA_WIDTH  to Memory.
- memory_read_data  in  DATA_WIDTH  from Memory.
- memory_response  in  1  from Memory.
- grant  out  3  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high in ACCESS or RESPOND.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; last_grant=2, so port 0 wins first under round-robin.
  - All outputs 0; latched op/address/data cleared.
  - Reset mid-transaction abandons it with no response pulse.
- Eligibility: port N eligible when mN_read|mN_write, and (N==0 or core_enable==1).
- Op select: write takes precedence when both read and write are high.
- IDLE:
  - Any eligible port: select winner, latch op/address/write_data/index, set grant, go to ACCESS.
  - Round-robin: search starts at (last_grant+1) mod 3.
  - Fixed priority: order 0, 2, 1.
  - No eligible port: stay in IDLE, memory signals 0.
- ACCESS:
  - Drive memory_read/memory_write/address/write_data from the latched registers, held steady until memory_response=1.
  - On memory_response: capture memory_read_data into the response register (zero for writes), update last_grant, drop memory_read/write next cycle, go to RESPOND.
- RESPOND:
  - Exactly one cycle: mN_response=1 for the latched N; mN_read_data = captured data.
  - All other ports: response 0, read_data 0.
  - Then IDLE; grant cleared.
- Latency:
  - Request seen in IDLE at cycle 0.
  - Memory op asserted at cycle 1.
  - memory_response at cycle k, so mN_response at cycle k+1.
  - Minimum 3 cycles request-to-response when Memory answers in 1 cycle.
- Requester rules:
  - Holds request and operands stable until its response.
  - Deasserts in the response cycle; a request still high in IDLE is a new transaction.
- Requests changing or dropping during ACCESS are ignored (operands already latched).
- core_enable falling during ACCESS for a core port: transaction completes normally.
- memory_response outside ACCESS is ignored.

Optional Feature:
- Macro: MEMORY_BUS_ARBITER_TIMEOUT_EN.
- Enabled:
  - Counter runs in ACCESS.
  - At TIMEOUT_CYCLES without memory_response: go to RESPOND, return read_data=32'hDEADBEEF, set sticky output timeout_error (1 bit, cleared only by reset).
  - The Memory request is deasserted.
- Disabled: no counter, no timeout_error port; ACCESS waits indefinitely.

Test Plan:
- Port 0 read of 32'h00000010 with Memory returning 32'hCAFEBABE after 1 cycle -> memory_read cycle 1; m0_response cycle 3 with m0_read_data=32'hCAFEBABE; grant=3'b001 during; m1/m2 responses 0.
- Round-robin, all three ports reading continuously from reset -> grant order 0,1,2,0,1,2; each port one response per rotation.
- priority_mode=1, ports 1 and 2 both requesting -> port 2 served first, then port 1; port 0 arriving in the RESPOND cycle is served before port 1.
- core_enable=0, ports 1 and 2 writing 32'h12345678 -> no memory_write, busy=0; raising core_enable -> port 1 served first (last_grant=2).
- Port 2 read and write both high, address 32'h00000020, data 32'h000000FF -> memory_write=1, memory_read=0; m2_read_data=0 on response.
- reset pulled low in ACCESS -> all outputs 0 immediately, no response pulse; after release, a pending port 1 request is served normally (timeout variant: no Memory response for 1024 cycles -> DEADBEEF, timeout_error=1).
